// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction control unit.
// State encoding, opcodes, ALU select codes and fault codes.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T1W,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_NEG  = 4'd5,
    ALU_NOT  = 4'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'b00,
    FLT_ILLEGAL = 2'b01,
    FLT_MEM     = 2'b10
  } fault_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Opcode decode: ALU select, unary/halt/illegal classification.
// Purely combinational so other control units can reuse it.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] op,
  output alu_op_t        alu_op,
  output logic           is_unary,
  output logic           is_halt,
  output logic           is_illegal
);

  always_comb begin
    alu_op     = ALU_NONE;
    is_unary   = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    unique case (op)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_NEG: begin
        alu_op   = ALU_NEG;
        is_unary = 1'b1;
      end
      OP_NOT: begin
        alu_op   = ALU_NOT;
        is_unary = 1'b1;
      end
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Hardwired fetch/execute sequencer for register ALU instructions.
// Strobes decode from the state register; MDRin also follows mem_ready.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t         state;
  fault_t         fault_q;
  logic [WW-1:0]  wait_cnt;
  alu_op_t        dec_op;
  logic           is_unary;
  logic           is_halt;
  logic           is_illegal;
  logic           unused_ir;

  assign unused_ir = ^ir[31-OPW:0];

  alu_seq_decode #(.OPW(OPW)) u_dec (
    .op         (ir[31 -: OPW]),
    .alu_op     (dec_op),
    .is_unary   (is_unary),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fault_q  <= FLT_NONE;
      retired  <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   state <= mem_ready ? S_T2 : S_T1W;
        S_T1W: begin
          if (mem_ready) begin
            state <= S_T2;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              state   <= S_HALT;
              fault_q <= FLT_MEM;
            end
          end
        end
        S_T2: begin
          wait_cnt <= '0;
          state    <= S_T3;
        end
        S_T3: begin
          if (is_illegal) begin
            state   <= S_HALT;
            fault_q <= FLT_ILLEGAL;
          end else if (is_halt) begin
            state <= S_HALT;
          end else begin
            state <= is_unary ? S_T5 : S_T4;
          end
        end
        S_T4: state <= S_T5;
        S_T5: begin
          retired <= retired + 1'b1;
          state   <= run ? S_T0 : S_IDLE;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fault = fault_q;

  // Only one of PCout/Zlowout/MDRout/Rout is ever set per state.
  always_comb begin
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    alu_op  = ALU_NONE;
    busy    = 1'b1;
    halted  = 1'b0;
    unique case (state)
      S_IDLE: busy = 1'b0;
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = mem_ready;
      end
      S_T1W: begin
        Read  = 1'b1;
        MDRin = mem_ready;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (!is_illegal && !is_halt) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          if (is_unary) begin
            alu_op = dec_op;
            Zin    = 1'b1;
          end else begin
            Yin = 1'b1;
          end
        end
      end
      S_T4: begin
        Grc    = 1'b1;
        Rout   = 1'b1;
        alu_op = dec_op;
        Zin    = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule
